mbinit_step_engine: RTL and testbench

MBINIT_STEP_ENGINE -- requirements
Module: mbinit_step_engine

---
 rtl/mbinit_step_engine.sv | 189 ++++++++++++++++++
 tb/tb_mbinit_step_engine.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mbinit_step_engine.sv
`default_nettype none
// ============================================================================
// mbinit_step_engine : MBINIT step handshake, local (module) and remote
// (partner) sideband FSMs sharing one transmitter.
// Optional feature macro: MBINIT_STEP_TIMEOUT_EN (wait-state timeouts).
// Rev 1.0
// ============================================================================
module mbinit_step_engine #(
   parameter int NUM_LANES      = 16,
   parameter int MAX_RETRY      = 3,
   parameter int TIMEOUT_CYCLES = 8000
) (
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic [3:0]           i_Rx_SbMessage,
   input  logic                 i_msg_valid,
   input  logic [NUM_LANES-1:0] i_rx_result,
   input  logic                 i_falling_edge_busy,
   input  logic                 i_pattern_done,
   input  logic [NUM_LANES-1:0] i_det_result,
   input  logic                 i_det_valid,
   output logic [3:0]           o_TX_SbMessage,
   output logic [NUM_LANES-1:0] o_tx_result,
   output logic                 o_ValidOutDatat,
   output logic                 o_Pattern_En,
   output logic                 o_step_end,
   output logic                 o_train_error_req
);
   localparam logic [3:0] INIT_REQ    = 4'd1;
   localparam logic [3:0] INIT_RESP   = 4'd2;
   localparam logic [3:0] RESULT_REQ  = 4'd3;
   localparam logic [3:0] RESULT_RESP = 4'd4;
   localparam logic [3:0] DONE_REQ    = 4'd5;
   localparam logic [3:0] DONE_RESP   = 4'd6;
   localparam int         RW          = $clog2(MAX_RETRY + 2);

   typedef enum logic [3:0] {
      M_IDLE, M_SEND_INIT, M_WAIT_INIT_RESP, M_PATTERN, M_SEND_RESULT_REQ,
      M_WAIT_RESULT_RESP, M_EVAL, M_SEND_DONE, M_WAIT_DONE_RESP, M_DONE, M_ERROR
   } m_state_t;

   typedef enum logic [3:0] {
      P_IDLE, P_WAIT_INIT_REQ, P_SEND_INIT_RESP, P_WAIT_RESULT_REQ, P_WAIT_DET,
      P_SEND_RESULT_RESP, P_WAIT_DONE_REQ, P_SEND_DONE_RESP, P_DONE
   } p_state_t;

   m_state_t             m_state, m_next;
   p_state_t             p_state, p_next;
   logic [RW-1:0]        retry_cnt;
   logic [NUM_LANES-1:0] rx_res;
   logic                 m_send, p_send, error, timeout, eval_pass;
   logic                 hit_init_req, hit_init_resp, hit_result_req;
   logic                 hit_result_resp, hit_done_req, hit_done_resp;

   assign hit_init_req    = i_msg_valid && (i_Rx_SbMessage == INIT_REQ);
   assign hit_init_resp   = i_msg_valid && (i_Rx_SbMessage == INIT_RESP);
   assign hit_result_req  = i_msg_valid && (i_Rx_SbMessage == RESULT_REQ);
   assign hit_result_resp = i_msg_valid && (i_Rx_SbMessage == RESULT_RESP);
   assign hit_done_req    = i_msg_valid && (i_Rx_SbMessage == DONE_REQ);
   assign hit_done_resp   = i_msg_valid && (i_Rx_SbMessage == DONE_RESP);

   assign m_send    = (m_state == M_SEND_INIT) || (m_state == M_SEND_RESULT_REQ) ||
                      (m_state == M_SEND_DONE);
   assign p_send    = (p_state == P_SEND_INIT_RESP) || (p_state == P_SEND_RESULT_RESP) ||
                      (p_state == P_SEND_DONE_RESP);
   assign error     = (m_state == M_ERROR);
   assign eval_pass = &rx_res;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         m_state     <= M_IDLE;
         p_state     <= P_IDLE;
         retry_cnt   <= '0;
         rx_res      <= '0;
         o_tx_result <= '0;
      end else begin
         m_state <= m_next;
         p_state <= p_next;
         if (m_state == M_EVAL && !eval_pass && retry_cnt != RW'(MAX_RETRY))
            retry_cnt <= retry_cnt + 1'b1;
         if (m_state == M_WAIT_RESULT_RESP && hit_result_resp)
            rx_res <= i_rx_result;
         if (p_state == P_WAIT_DET && i_det_valid && !error)
            o_tx_result <= i_det_result;
      end
   end

   // The module side may only finish a send while the partner is not holding the transmitter.
   always_comb begin
      m_next = m_state;
      case (m_state)
         M_IDLE:             if (i_start) m_next = M_SEND_INIT;
         M_SEND_INIT:        if (!p_send && i_falling_edge_busy) m_next = M_WAIT_INIT_RESP;
         M_WAIT_INIT_RESP:   if (hit_init_resp) m_next = M_PATTERN;
         M_PATTERN:          if (i_pattern_done) m_next = M_SEND_RESULT_REQ;
         M_SEND_RESULT_REQ:  if (!p_send && i_falling_edge_busy) m_next = M_WAIT_RESULT_RESP;
         M_WAIT_RESULT_RESP: if (hit_result_resp) m_next = M_EVAL;
         M_EVAL: begin
            if (eval_pass)                         m_next = M_SEND_DONE;
            else if (retry_cnt == RW'(MAX_RETRY))  m_next = M_ERROR;
            else                                   m_next = M_PATTERN;
         end
         M_SEND_DONE:        if (!p_send && i_falling_edge_busy) m_next = M_WAIT_DONE_RESP;
         M_WAIT_DONE_RESP:   if (hit_done_resp) m_next = M_DONE;
         default:            ;
      endcase
      if (timeout && !error)
         m_next = M_ERROR;
   end

   always_comb begin
      p_next = p_state;
      if (!error) begin
         case (p_state)
            P_IDLE:             if (i_start) p_next = P_WAIT_INIT_REQ;
            P_WAIT_INIT_REQ:    if (hit_init_req) p_next = P_SEND_INIT_RESP;
            P_SEND_INIT_RESP:   if (i_falling_edge_busy) p_next = P_WAIT_RESULT_REQ;
            P_WAIT_RESULT_REQ: begin
               if (hit_result_req)    p_next = P_WAIT_DET;
               else if (hit_done_req) p_next = P_SEND_DONE_RESP;
            end
            P_WAIT_DET:         if (i_det_valid) p_next = P_SEND_RESULT_RESP;
            P_SEND_RESULT_RESP: if (i_falling_edge_busy)
                                   p_next = (&o_tx_result) ? P_WAIT_DONE_REQ : P_WAIT_RESULT_REQ;
            P_WAIT_DONE_REQ:    if (hit_done_req) p_next = P_SEND_DONE_RESP;
            P_SEND_DONE_RESP:   if (i_falling_edge_busy) p_next = P_DONE;
            default:            ;
         endcase
      end
   end

   always_comb begin
      o_ValidOutDatat = 1'b0;
      o_TX_SbMessage  = 4'd0;
      if (!error) begin
         if (p_send) begin
            o_ValidOutDatat = 1'b1;
            case (p_state)
               P_SEND_INIT_RESP:   o_TX_SbMessage = INIT_RESP;
               P_SEND_RESULT_RESP: o_TX_SbMessage = RESULT_RESP;
               default:            o_TX_SbMessage = DONE_RESP;
            endcase
         end else if (m_send) begin
            o_ValidOutDatat = 1'b1;
            case (m_state)
               M_SEND_INIT:       o_TX_SbMessage = INIT_REQ;
               M_SEND_RESULT_REQ: o_TX_SbMessage = RESULT_REQ;
               default:           o_TX_SbMessage = DONE_REQ;
            endcase
         end
      end
   end

   assign o_Pattern_En      = (m_state == M_PATTERN);
   assign o_step_end        = (m_state == M_DONE) && (p_state == P_DONE);
   assign o_train_error_req = error;

`ifdef MBINIT_STEP_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] m_to_cnt, p_to_cnt;
   logic          m_wait, p_wait;

   assign m_wait = (m_state == M_WAIT_INIT_RESP) || (m_state == M_WAIT_RESULT_RESP) ||
                   (m_state == M_WAIT_DONE_RESP);
   assign p_wait = (p_state == P_WAIT_INIT_REQ) || (p_state == P_WAIT_RESULT_REQ) ||
                   (p_state == P_WAIT_DET) || (p_state == P_WAIT_DONE_REQ);

   // A state change zeroes the count, so each wait starts from 0 on entry.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         m_to_cnt <= '0;
         p_to_cnt <= '0;
      end else begin
         m_to_cnt <= (m_wait && m_next == m_state) ? m_to_cnt + 1'b1 : '0;
         p_to_cnt <= (p_wait && p_next == p_state) ? p_to_cnt + 1'b1 : '0;
      end
   end

   assign timeout = (m_wait && m_to_cnt == TW'(TIMEOUT_CYCLES - 1)) ||
                    (p_wait && p_to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Waits are unbounded here; the parameter stays on the interface for both builds.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mbinit_step_engine.sv
`default_nettype none
// tb_mbinit_step_engine: table of loopback training runs plus directed corner sequences.
module tb_mbinit_step_engine;
   localparam int NL = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_start;
   logic [3:0]    i_Rx_SbMessage;
   logic          i_msg_valid;
   logic [NL-1:0] i_rx_result;
   logic          i_falling_edge_busy;
   logic          i_pattern_done;
   logic [NL-1:0] i_det_result;
   logic          i_det_valid;
   logic [3:0]    o_TX_SbMessage;
   logic [NL-1:0] o_tx_result;
   logic          o_ValidOutDatat;
   logic          o_Pattern_En;
   logic          o_step_end;
   logic          o_train_error_req;

   mbinit_step_engine #(.NUM_LANES(NL), .MAX_RETRY(3), .TIMEOUT_CYCLES(100)) dut (
      .CLK(clk), .rst_n(rst_n), .i_start(i_start), .i_Rx_SbMessage(i_Rx_SbMessage),
      .i_msg_valid(i_msg_valid), .i_rx_result(i_rx_result),
      .i_falling_edge_busy(i_falling_edge_busy), .i_pattern_done(i_pattern_done),
      .i_det_result(i_det_result), .i_det_valid(i_det_valid),
      .o_TX_SbMessage(o_TX_SbMessage), .o_tx_result(o_tx_result),
      .o_ValidOutDatat(o_ValidOutDatat), .o_Pattern_En(o_Pattern_En),
      .o_step_end(o_step_end), .o_train_error_req(o_train_error_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0][15:0] det;      // det[k] = detector result for pattern round k
      int               exp_entries;
      bit               exp_pass;
   } vec_t;

   vec_t             tbl [6];
   int               tests = 0;
   int               fails = 0;
   logic [3:0]       sent_q [$];
   logic [3:0]       exp_q [$];
   logic [3:0][15:0] dets;
   bit               link_en, loop_en, pend, prev_pat;
   logic [3:0]       pend_code;
   logic [NL-1:0]    pend_res;
   int               busy_cnt, pat_cnt, entries;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, input int n, input bit p);
      vec_t v;
      v.det = {d3, d2, d1, d0};
      v.exp_entries = n;
      v.exp_pass = p;
      return v;
   endfunction

   // One clock of the link model: delivers looped messages, acks transmits
   // after 3 busy cycles, and runs the pattern generator for 2 cycles.
   task automatic step();
      logic [1:0] di;
      @(negedge clk);
      i_falling_edge_busy = 1'b0;
      i_msg_valid         = 1'b0;
      i_pattern_done      = 1'b0;
      if (pend) begin
         i_msg_valid    = 1'b1;
         i_Rx_SbMessage = pend_code;
         i_rx_result    = pend_res;
         pend           = 1'b0;
      end
      if (o_Pattern_En) begin
         if (!prev_pat) begin
            entries++;
            di = (entries > 4) ? 2'd3 : 2'(entries - 1);
            i_det_result = dets[di];
         end
         pat_cnt++;
         if (pat_cnt == 2) begin
            i_pattern_done = 1'b1;
            pat_cnt = 0;
         end
      end else begin
         pat_cnt = 0;
      end
      prev_pat = o_Pattern_En;
      if (link_en && o_ValidOutDatat) begin
         busy_cnt++;
         if (busy_cnt == 3) begin
            i_falling_edge_busy = 1'b1;
            busy_cnt = 0;
            sent_q.push_back(o_TX_SbMessage);
            if (loop_en) begin
               pend      = 1'b1;
               pend_code = o_TX_SbMessage;
               pend_res  = o_tx_result;
            end
         end
      end else begin
         busy_cnt = 0;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_start = 1'b0; i_Rx_SbMessage = 4'd0; i_msg_valid = 1'b0; i_rx_result = '0;
      i_falling_edge_busy = 1'b0; i_pattern_done = 1'b0; i_det_result = '0; i_det_valid = 1'b0;
      link_en = 1'b0; loop_en = 1'b0; pend = 1'b0; prev_pat = 1'b0;
      busy_cnt = 0; pat_cnt = 0; entries = 0;
      sent_q.delete();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int n = 0;
      dets = v.det;
      link_en = 1'b1; loop_en = 1'b1; i_det_valid = 1'b1; i_start = 1'b1;
      while (!o_step_end && !o_train_error_req && n < 500) begin
         step();
         n++;
      end
      chk($sformatf("v%0d_budget", id), int'(n < 500), 1);
      chk($sformatf("v%0d_step_end", id), int'(o_step_end), int'(v.exp_pass));
      chk($sformatf("v%0d_error", id), int'(o_train_error_req), int'(!v.exp_pass));
      chk($sformatf("v%0d_pattern_entries", id), entries, v.exp_entries);
      chk($sformatf("v%0d_valid_idle", id), int'(o_ValidOutDatat), 0);
      exp_q.delete();
      exp_q.push_back(4'd1); exp_q.push_back(4'd2);
      for (int k = 0; k < v.exp_entries; k++) begin
         exp_q.push_back(4'd3); exp_q.push_back(4'd4);
      end
      if (v.exp_pass) begin
         exp_q.push_back(4'd5); exp_q.push_back(4'd6);
      end
      chk($sformatf("v%0d_msg_count", id), sent_q.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < sent_q.size(); k++)
         chk($sformatf("v%0d_msg%0d", id, k), int'(sent_q[k]), int'(exp_q[k]));
      if (v.exp_pass)
         chk($sformatf("v%0d_tx_result", id), int'(o_tx_result), int'(v.det[v.exp_entries-1]));
      repeat (5) step();
      chk($sformatf("v%0d_sticky_end", id), int'(o_step_end), int'(v.exp_pass));
      chk($sformatf("v%0d_sticky_err", id), int'(o_train_error_req), int'(!v.exp_pass));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1'b1);
      tbl[1] = mk(16'hFFFE, 16'hFFFE, 16'hFFFF, 16'hFFFF, 3, 1'b1);
      tbl[2] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 4, 1'b0);
      tbl[3] = mk(16'h7FFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 1'b1);
      tbl[4] = mk(16'hFFFE, 16'hBFFF, 16'h0001, 16'hFFFF, 4, 1'b1);
      tbl[5] = mk(16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 4, 1'b0);

      // Reset state, with i_start already high.
      do_reset();
      rst_n = 1'b0;
      i_start = 1'b1;
      step();
      chk("reset_outputs", int'({o_ValidOutDatat, o_TX_SbMessage, o_Pattern_En,
                                 o_step_end, o_train_error_req}), 0);
      chk("reset_tx_result", int'(o_tx_result), 0);

      for (int i = 0; i < 6; i++) begin
         do_reset();
         run_vec(tbl[i], i);
      end

      // Simultaneous sends: partner reply first, module request stalls until next ack.
      do_reset();
      i_start = 1'b1;
      step(); step();
      chk("sim_module_code", int'({o_ValidOutDatat, o_TX_SbMessage}), int'({1'b1, 4'd1}));
      pend = 1'b1; pend_code = 4'd1; pend_res = '0;
      step(); step();
      chk("sim_partner_first", int'({o_ValidOutDatat, o_TX_SbMessage}), int'({1'b1, 4'd2}));
      step(); step();
      chk("sim_stall_stable", int'(o_TX_SbMessage), 2);
      link_en = 1'b1;
      n = 0;
      while (sent_q.size() < 1 && n < 30) begin step(); n++; end
      step();
      chk("sim_module_after_ack", int'({o_ValidOutDatat, o_TX_SbMessage}), int'({1'b1, 4'd1}));
      while (sent_q.size() < 2 && n < 30) begin step(); n++; end
      chk("sim_send_count", sent_q.size(), 2);
      if (sent_q.size() == 2)
         chk("sim_order", int'({sent_q[0], sent_q[1]}), int'({4'd2, 4'd1}));
      step();
      chk("sim_both_waiting", int'(o_ValidOutDatat), 0);
      // Unexpected code while waiting for INIT_RESP is dropped.
      pend = 1'b1; pend_code = 4'd4;
      step(); step();
      chk("drop_unexpected", int'(o_Pattern_En), 0);
      pend = 1'b1; pend_code = 4'd2;
      step(); step();
      chk("accept_init_resp", int'(o_Pattern_En), 1);

      // INIT_RESP never returned: timeout build errors 100 cycles into WAIT_INIT_RESP.
      do_reset();
      link_en = 1'b1;
      i_start = 1'b1;
      n = 0;
      while (sent_q.size() < 1 && n < 30) begin step(); n++; end
      pend = 1'b1; pend_code = 4'd1;
      step();
`ifdef MBINIT_STEP_TIMEOUT_EN
      repeat (99) step();
      chk("timeout_not_early", int'(o_train_error_req), 0);
      step();
      chk("timeout_error", int'(o_train_error_req), 1);
      chk("timeout_valid_low", int'(o_ValidOutDatat), 0);
`else
      repeat (149) step();
      chk("no_timeout_error", int'(o_train_error_req), 0);
      chk("no_timeout_still_waiting", int'(o_Pattern_En), 0);
`endif

      // Asynchronous reset in PATTERN (second round), then a clean passing run.
      do_reset();
      dets = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE};
      link_en = 1'b1; loop_en = 1'b1; i_det_valid = 1'b1; i_start = 1'b1;
      n = 0;
      while (!(entries == 2 && o_Pattern_En) && n < 200) begin step(); n++; end
      chk("mid_reach_pattern", int'(o_Pattern_En), 1);
      chk("mid_tx_latched", int'(o_tx_result), 16'hFFFE);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_async_outputs", int'({o_ValidOutDatat, o_TX_SbMessage, o_Pattern_En,
                                     o_step_end, o_train_error_req}), 0);
      chk("mid_async_tx_result", int'(o_tx_result), 0);
      do_reset();
      run_vec(tbl[0], 10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
